// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, default sizes and sample-point helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS = 8;
  function automatic int mid_sample(input int oversample);
    return oversample / 2;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: rx synchroniser with falling-edge detect and baud_clk rising-edge tick
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic baud_clk,
  input  logic restart,
  output logic rx_s,
  output logic fall,
  output logic tick
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_prev;
  logic baud_prev;
  // synchronise rx, delay it once for edge detect, and remember baud_clk; a restart forgets the old baud phase
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rx_prev <= 1'b1;
      baud_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
      baud_prev <= restart ? 1'b0 : baud_clk;
    end
  end
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev & ~rx_s;
  assign tick = baud_clk & ~baud_prev & ~restart;
endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled UART receiver with valid/ready output; UART_RX_PARITY_EN adds a parity bit and parity_err
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 baud_clk,
  output logic                 restart_baud_clk,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);
  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID_LAST = TW'(mid_sample(OVERSAMPLE) - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  rx_state_t state, state_n;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic rx_s, fall, tick, mid_hit, bit_hit, par_ok;
  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .baud_clk(baud_clk),
    .restart(restart_baud_clk),
    .rx_s(rx_s),
    .fall(fall),
    .tick(tick)
  );
  assign mid_hit = tick && tick_cnt == MID_LAST;
  assign bit_hit = tick && tick_cnt == BIT_LAST;
  assign busy = state != IDLE;
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
  logic par_bit;
  assign par_ok = (^shift_reg ^ par_bit) == PARITY_ODD;
  // capture the parity bit and flag a mismatch only when the stop bit is good
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= state == STOP && bit_hit && rx_s && !par_ok;
      if (state == PARITY && bit_hit) par_bit <= rx_s;
    end
  end
`else
  localparam rx_state_t AFTER_DATA = STOP;
  assign par_ok = 1'b1;
`endif
  // frame sequencing: start is checked mid-bit, later bits one full bit apart
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fall ? START : IDLE;
      START:   state_n = mid_hit ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_n = (bit_hit && bit_cnt == LAST_BIT) ? AFTER_DATA : DATA;
      PARITY:  state_n = bit_hit ? STOP : PARITY;
      STOP:    state_n = bit_hit ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // counters, deserialiser and output handshake; a good byte may load in the same cycle the old one is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      restart_baud_clk <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
    end else begin
      restart_baud_clk <= state == IDLE && fall;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= (state == START ? mid_hit : bit_hit) ? '0 : tick_cnt + 1'b1;
      end
      if (state == DATA && bit_hit) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == STOP && bit_hit) begin
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (par_ok) begin
          if (rx_valid && !rx_ready) begin
            overrun <= 1'b1;
          end else begin
            rx_data <= shift_reg;
            rx_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: frame-level self-checking bench with a behavioural baud generator
module tb_uart_rx_oversampled;
  localparam int HALF = 3;
  localparam int BIT = 2 * HALF * 16;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic baud_clk = 1'b0;
  logic rx_ready = 1'b1;
  logic restart_baud_clk, rx_valid, frame_err, overrun, busy;
  logic [7:0] rx_data;
  int n_cmp = 0, n_fail = 0;
  int n_bytes = 0, n_ferr = 0, n_ovr = 0, n_rst = 0;
  int s_bytes, s_ferr, s_ovr, s_rst;
  logic [7:0] last_byte = 8'h00;
  int bcnt = 0;
  vec_t vecs[6];

  uart_rx_oversampled dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .baud_clk(baud_clk),
    .restart_baud_clk(restart_baud_clk),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // baud generator: free-running divide by 2*HALF, realigned low by restart
  always @(posedge clk) begin
    if (restart_baud_clk) begin
      bcnt <= 0;
      baud_clk <= 1'b0;
    end else if (bcnt == HALF - 1) begin
      bcnt <= 0;
      baud_clk <= ~baud_clk;
    end else begin
      bcnt <= bcnt + 1;
    end
  end

  // event monitor: accepted bytes and pulse counts
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      n_bytes++;
      last_byte = rx_data;
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (restart_baud_clk) n_rst++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    s_bytes = n_bytes;
    s_ferr = n_ferr;
    s_ovr = n_ovr;
    s_rst = n_rst;
  endtask

  task automatic tx(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT);
    end
    rx = stop;
    wait_clk(BIT);
  endtask

  task automatic chk_frame(input string nm, input int eb, input logic [7:0] ed, input int ef);
    chk({nm, " bytes"}, n_bytes - s_bytes, eb);
    if (eb > 0) chk({nm, " data"}, last_byte, ed);
    chk({nm, " frame_err"}, n_ferr - s_ferr, ef);
    chk({nm, " overrun"}, n_ovr - s_ovr, 0);
    chk({nm, " restarts"}, n_rst - s_rst, 1);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] d, input logic stop, input int gap,
                           input int eb, input int ef);
    mark();
    tx(d, stop);
    if (!stop) wait_clk(gap);
    chk_frame(nm, eb, d, ef);
    if (!stop) begin
      chk({nm, " busy in break"}, busy, 0);
      chk({nm, " valid"}, rx_valid, 0);
      rx = 1'b1;
      wait_clk(BIT);
    end else begin
      wait_clk(gap);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic st;
    int gap;
    vecs[0] = '{8'hA5, 1'b1, 200, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0, 1, 0};
    vecs[3] = '{8'h55, 1'b1, 200, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 3 * BIT, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 200, 1, 0};
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    chk("reset restart", restart_baud_clk, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset busy", busy, 0);
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop, vecs[i].gap,
                vecs[i].exp_bytes, vecs[i].exp_ferr);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      st = $urandom_range(0, 3) != 0;
      gap = st ? $urandom_range(0, 150) : $urandom_range(0, 2 * BIT);
      run_frame($sformatf("rand%0d", i), d, st, gap, st ? 1 : 0, st ? 0 : 1);
    end
    mark();
    rx = 1'b0;
    wait_clk(30);
    rx = 1'b1;
    wait_clk(2 * BIT);
    chk("glitch restarts", n_rst - s_rst, 1);
    chk("glitch bytes", n_bytes - s_bytes, 0);
    chk("glitch frame_err", n_ferr - s_ferr, 0);
    chk("glitch busy", busy, 0);
    rx_ready = 1'b0;
    mark();
    tx(8'h11, 1'b1);
    wait_clk(BIT);
    tx(8'h22, 1'b1);
    wait_clk(BIT);
    chk("ovr valid held", rx_valid, 1);
    chk("ovr data held", rx_data, 8'h11);
    chk("ovr pulses", n_ovr - s_ovr, 1);
    chk("ovr frame_err", n_ferr - s_ferr, 0);
    chk("ovr restarts", n_rst - s_rst, 2);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    wait_clk(3);
    chk("ovr valid cleared", rx_valid, 0);
    chk("ovr accepted", n_bytes - s_bytes, 1);
    chk("ovr accepted data", last_byte, 8'h11);
    mark();
    d = 8'h7E;
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_clk(BIT);
    end
    rx = d[4];
    wait_clk(BIT / 2);
    chk("mid busy", busy, 1);
    rst = 1'b1;
    wait_clk(1);
    chk("rst restart", restart_baud_clk, 0);
    chk("rst rx_data", rx_data, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst overrun", overrun, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    rx = 1'b1;
    wait_clk(2 * BIT);
    chk("rst partial bytes", n_bytes - s_bytes, 0);
    chk("rst partial frame_err", n_ferr - s_ferr, 0);
    run_frame("after rst", 8'h42, 1'b1, 100, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
